// File: rtl/tcam_search.sv
// Sequential ternary-CAM search: scans an external entry RAM for the lowest matching index.
// Optional TCAM_SEARCH_MULTIHIT_EN: full scan with multi-match reporting instead of early exit.
//
// state  | meaning
// IDLE   | waiting for a key, key_ready high
// SCAN   | stepping rd_addr and comparing returned entries
// RESULT | result presented, held until res_ready
module tcam_search #(
  parameter int KEY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [KEY_WIDTH-1:0]    key,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [2*KEY_WIDTH-1:0]  rd_data,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_hit,
  output logic [ADDR_WIDTH-1:0]   res_index,
  output logic                    res_multi
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  state_t                state, state_next;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  dv;
  logic                  hit_q, hit_n;
  logic [ADDR_WIDTH-1:0] idx_q, idx_n;
  logic [KEY_WIDTH-1:0]  ent_mask, ent_value;
  logic                  match, last;
  logic                  accept;
`ifdef TCAM_SEARCH_MULTIHIT_EN
  logic                  multi_q, multi_n;
`endif

  assign ent_mask  = rd_data[2*KEY_WIDTH-1:KEY_WIDTH];
  assign ent_value = rd_data[KEY_WIDTH-1:0];
  // An all-zero mask marks an empty slot, which must never match.
  assign match  = dv && (ent_mask != '0) && (((ent_value ^ key_q) & ent_mask) == '0);
  assign last   = dv && (addr_q == LAST);
  assign accept = (state == IDLE) && key_valid;

  always_comb begin
    state_next = state;
    hit_n      = hit_q;
    idx_n      = idx_q;
`ifdef TCAM_SEARCH_MULTIHIT_EN
    multi_n    = multi_q;
`endif
    case (state)
      IDLE: begin
        if (key_valid) state_next = SCAN;
      end
      SCAN: begin
`ifdef TCAM_SEARCH_MULTIHIT_EN
        if (match) begin
          if (hit_q) begin
            multi_n = 1'b1;
          end else begin
            hit_n = 1'b1;
            idx_n = addr_q;
          end
        end
        if (last) state_next = RESULT;
`else
        if (match) begin
          hit_n      = 1'b1;
          idx_n      = addr_q;
          state_next = RESULT;
        end else if (last) begin
          state_next = RESULT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      dv      <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
`ifdef TCAM_SEARCH_MULTIHIT_EN
      multi_q <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      addr_q <= cnt;
      // Data returned after leaving SCAN belongs to no search; drop it.
      dv     <= (state == SCAN) && (state_next == SCAN);
      if (accept) begin
        key_q   <= key;
        cnt     <= '0;
        hit_q   <= 1'b0;
        idx_q   <= '0;
`ifdef TCAM_SEARCH_MULTIHIT_EN
        multi_q <= 1'b0;
`endif
      end else begin
        if ((state == SCAN) && (cnt != LAST)) cnt <= cnt + 1'b1;
        hit_q   <= hit_n;
        idx_q   <= idx_n;
`ifdef TCAM_SEARCH_MULTIHIT_EN
        multi_q <= multi_n;
`endif
      end
    end
  end

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rd_addr   = (state == SCAN) ? cnt : '0;
  assign res_valid = (state == RESULT);
  assign res_hit   = hit_q;
  assign res_index = idx_q;
`ifdef TCAM_SEARCH_MULTIHIT_EN
  assign res_multi = multi_q;
`else
  assign res_multi = 1'b0;
`endif

endmodule

// File: tb/tb_tcam_search.sv
// Directed bench for tcam_search: table of single-search vectors plus
// backpressure and mid-scan reset sequences against a registered RAM model.
module tb_tcam_search;

`ifdef TCAM_SEARCH_MULTIHIT_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [7:0]  key;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic        res_hit;
  logic [7:0]  res_index;
  logic        res_multi;

  logic [15:0] mem [256];

  int tests = 0;
  int fails = 0;

  tcam_search #(.KEY_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_index(res_index), .res_multi(res_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    int          a0;
    logic [15:0] d0;
    int          a1;
    logic [15:0] d1;
    logic [7:0]  k;
    int          hit;
    int          idx;
    int          multi;
    int          edges;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Offer a key, count rising edges from acceptance until res_valid.
  task automatic start_search(input logic [7:0] k, output int edges);
    @(negedge clk);
    chk("key_ready_before_accept", int'(key_ready), 1);
    key_valid = 1'b1;
    key       = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    edges = 0;
    while (!res_valid && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic finish_search();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("key_ready_after_release", int'(key_ready), 1);
    chk("busy_after_release", int'(busy), 0);
  endtask

  initial begin
    int edges;
    logic [7:0] h_idx;
    logic       h_hit;

    rst_n = 1'b0; key_valid = 1'b0; res_ready = 1'b0; key = 8'h00;
    clear_mem();

    vecs[0] = '{5,   16'hFF3C, -1, 16'h0000, 8'h3C, 1, 5,   0,       MH ? 257 : 7};
    vecs[1] = '{2,   16'hF0A0, -1, 16'h0000, 8'hA7, 1, 2,   0,       MH ? 257 : 4};
    vecs[2] = '{2,   16'hF0A0, -1, 16'h0000, 8'hB7, 0, 0,   0,       257};
    vecs[3] = '{-1,  16'h0000, -1, 16'h0000, 8'h00, 0, 0,   0,       257};
    vecs[4] = '{-1,  16'h0000, -1, 16'h0000, 8'h5A, 0, 0,   0,       257};
    vecs[5] = '{3,   16'hFF11,  9, 16'hFF11, 8'h11, 1, 3,   int'(MH), MH ? 257 : 5};
    vecs[6] = '{255, 16'hFF77, -1, 16'h0000, 8'h77, 1, 255, 0,       257};
    vecs[7] = '{0,   16'h0F05, -1, 16'h0000, 8'hF5, 1, 0,   0,       MH ? 257 : 2};
    vecs[8] = '{10,  16'h0042, -1, 16'h0000, 8'h42, 0, 0,   0,       257};
    vecs[9] = '{4,   16'hFF80,  6, 16'hC0C0, 8'hC1, 1, 6,   0,       MH ? 257 : 8};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", int'(key_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_res_hit", int'(res_hit), 0);
    chk("rst_res_index", int'(res_index), 0);
    chk("rst_res_multi", int'(res_multi), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      clear_mem();
      if (vecs[v].a0 >= 0) mem[vecs[v].a0] = vecs[v].d0;
      if (vecs[v].a1 >= 0) mem[vecs[v].a1] = vecs[v].d1;
      start_search(vecs[v].k, edges);
      chk($sformatf("v%0d_edges", v), edges, vecs[v].edges);
      chk($sformatf("v%0d_hit", v), int'(res_hit), vecs[v].hit);
      chk($sformatf("v%0d_index", v), int'(res_index), vecs[v].idx);
      chk($sformatf("v%0d_multi", v), int'(res_multi), vecs[v].multi);
      chk($sformatf("v%0d_busy", v), int'(busy), 1);
      finish_search();
    end

    // Backpressure: result must hold and a competing key must be ignored.
    clear_mem();
    mem[5] = 16'hFF3C;
    mem[7] = 16'hFF99;
    start_search(8'h3C, edges);
    chk("bp_edges", edges, MH ? 257 : 7);
    h_hit = res_hit;
    h_idx = res_index;
    chk("bp_hit", int'(h_hit), 1);
    chk("bp_index", int'(h_idx), 5);
    @(negedge clk);
    key_valid = 1'b1;
    key       = 8'h99;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_c%0d", c), int'(res_valid), 1);
      chk($sformatf("bp_key_ready_c%0d", c), int'(key_ready), 0);
      chk($sformatf("bp_index_c%0d", c), int'(res_index), 5);
      chk($sformatf("bp_hit_c%0d", c), int'(res_hit), 1);
      chk($sformatf("bp_rd_addr_c%0d", c), int'(rd_addr), 0);
    end
    key_valid = 1'b0;
    finish_search();

    // Reset in the middle of a scan, then a fresh search from index 0.
    clear_mem();
    @(negedge clk);
    key_valid = 1'b1;
    key       = 8'h99;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    edges = 0;
    while (rd_addr != 8'd100 && edges < 300) begin
      @(negedge clk);
      edges++;
    end
    chk("mid_reached_addr100", int'(rd_addr), 100);
    chk("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rd_addr", int'(rd_addr), 0);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_res_hit", int'(res_hit), 0);
    chk("mid_rst_res_index", int'(res_index), 0);
    chk("mid_rst_res_multi", int'(res_multi), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_key_ready_after_rst", int'(key_ready), 1);
    mem[0] = 16'hFF01;
    start_search(8'h01, edges);
    chk("mid_next_edges", edges, MH ? 257 : 2);
    chk("mid_next_hit", int'(res_hit), 1);
    chk("mid_next_index", int'(res_index), 0);
    finish_search();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tcam_search.md
TCAM_SEARCH -- requirements
Module: tcam_search

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 8, meaning search key width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning entry index width; table depth is 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port key_valid  input  1  meaning a search key is offered.
REQ-006 SHALL have port key_ready  output  1  meaning the block accepts a key.
REQ-007 SHALL have port key  input  KEY_WIDTH  meaning the search key.
REQ-008 SHALL have port rd_addr  output  ADDR_WIDTH  meaning the read address to the entry RAM.
REQ-009 SHALL have port rd_data  input  2*KEY_WIDTH  meaning the registered RAM read data, valid one cycle after rd_addr; layout is mask in [2*KEY_WIDTH-1:KEY_WIDTH] and value in [KEY_WIDTH-1:0].
REQ-010 SHALL have port busy  output  1  meaning a search is in progress; the RAM owner must not write while busy is high.
REQ-011 SHALL have port res_valid  output  1  meaning a result is presented.
REQ-012 SHALL have port res_ready  input  1  meaning the consumer takes the result.
REQ-013 SHALL have port res_hit  output  1  meaning at least one entry matched.
REQ-014 SHALL have port res_index  output  ADDR_WIDTH  meaning the lowest matching index, or 0 on a miss.
REQ-015 SHALL have port res_multi  output  1  meaning more than one entry matched.

Function
REQ-016 SHALL implement the FSM IDLE -> SCAN -> RESULT -> IDLE.
REQ-017 SHALL drive key_ready = 1 only in IDLE; a key_valid&&key_ready edge latches key, clears the scan counter to 0 and enters SCAN.
REQ-018 SHALL drive rd_addr from the scan counter in SCAN, which increments by 1 per cycle and does not wrap past 2**ADDR_WIDTH-1; rd_addr = 0 outside SCAN.
REQ-019 SHALL compare rd_data in the cycle after its address was driven, tracked by a registered data-valid flag and a registered copy of the address.
REQ-020 SHALL treat an entry as matching iff mask != 0 and (value & mask) == (key & mask); entries with mask == 0 are empty and never match.
REQ-021 SHALL, when a hit at index i is the first match, enter RESULT and assert res_valid on edge i+2 after the acceptance edge (early exit).
REQ-022 SHALL, on a full miss, enter RESULT with res_hit = 0 and res_index = 0 on edge 2**ADDR_WIDTH+1 after the acceptance edge.
REQ-023 SHALL hold res_hit, res_index, res_multi and res_valid stable in RESULT until res_ready = 1, then return to IDLE on that edge; key_ready rises the following cycle.
REQ-024 SHALL drive busy = 1 in SCAN and RESULT.
REQ-025 SHALL match a hit at index 2**ADDR_WIDTH-1 with the same timing as any other final compare (edge 2**ADDR_WIDTH+1).

Reset
REQ-026 SHALL, on rst_n low at any time including mid-scan, immediately force IDLE with key_ready = 1 after release, rd_addr = 0, busy = 0, res_valid = 0, res_hit = 0, res_index = 0, res_multi = 0, and clear the data-valid flag; an in-flight search is discarded.

Configuration
REQ-027 SHALL, with TCAM_SEARCH_MULTIHIT_EN defined, disable the early exit, always scan all entries, and report the lowest index plus res_multi = 1 if two or more entries matched.
REQ-028 SHALL, with TCAM_SEARCH_MULTIHIT_EN defined, assert res_valid on edge 2**ADDR_WIDTH+1 after the acceptance edge for both hit and miss.
REQ-029 SHALL, without TCAM_SEARCH_MULTIHIT_EN, use the early-exit timing of REQ-021 and tie res_multi to 0.

Verification
REQ-030 SHALL cover a single hit: entry 5 = mask 0xFF, value 0x3C; key 0x3C -> res_hit = 1, res_index = 5, res_valid on edge 7.
REQ-031 SHALL cover a ternary hit: entry 2 = mask 0xF0, value 0xA0; key 0xA7 -> hit at index 2; key 0xB7 -> miss, res_valid on edge 257, res_index = 0.
REQ-032 SHALL cover an empty table (all zeros): any key -> res_hit = 0, because mask == 0 entries never match.
REQ-033 SHALL cover multihit: entries 3 and 9 both match key 0x11 -> res_index = 3; res_multi = 1 and edge 257 with the macro, res_multi = 0 and edge 5 without it.
REQ-034 SHALL cover backpressure: res_ready held low for 10 cycles -> outputs stable, key_ready = 0, and a key offered meanwhile is not accepted.
REQ-035 SHALL cover reset mid-scan: rst_n pulsed at scan address 100 -> all outputs at reset values, and the next key scans from index 0.
